// File: rtl/pipeline_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_perf_monitor
// Brief    : Cycle and event counters with a cycle limit, sticky overflow flags
//            and a snapshot bank that is read back through a registered mux.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_perf_monitor #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1,
  parameter int SEL_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic [1:0]         state_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam logic [1:0]       c_IDLE  = 2'b00;
  localparam logic [1:0]       c_RUN   = 2'b01;
  localparam logic [1:0]       c_PAUSE = 2'b10;
  localparam logic [1:0]       c_DONE  = 2'b11;
  localparam logic [CNT_W-1:0] c_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Index 0 is the cycle counter, index k is event channel k-1.
  logic [CNT_W-1:0] r_cnt    [0:NUM_EVT];
  logic [CNT_W-1:0] r_shadow [0:NUM_EVT];
  logic [CNT_W-1:0] w_nxt    [0:NUM_EVT];
  logic [NUM_EVT:0] w_inc;
  logic [NUM_EVT:0] w_ovf_set;
  logic [NUM_EVT:0] r_ovf;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_rd_data;
  logic [CNT_W-1:0] w_rd_mux;
  logic             w_count;
  logic             w_hit;

  assign w_count = start_i && (r_state != c_DONE);

  generate
    for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cnt
      logic w_all1;
      logic w_step;
      if (i == 0) begin : g_cyc
        assign w_inc[i] = 1'b1;
      end else begin : g_evt
        assign w_inc[i] = evt_i[i-1];
      end
      assign w_all1       = &r_cnt[i];
      assign w_step       = w_count && w_inc[i];
      assign w_ovf_set[i] = w_step && w_all1;
      assign w_nxt[i]     = !w_step ? r_cnt[i] :
                            w_all1  ? ((SATURATE != 0) ? r_cnt[i] : '0) :
                                      r_cnt[i] + c_ONE;
    end
  endgenerate

  // Equality compare: a limit lowered below the live count is never reached.
  assign w_hit = w_count && (limit_i != '0) && (w_nxt[0] == limit_i);

  always_comb begin
    w_state_nxt = r_state;
    if (w_hit) begin
      w_state_nxt = c_DONE;
    end else if (w_count) begin
      w_state_nxt = c_RUN;
    end else if (r_state == c_RUN) begin
      w_state_nxt = c_PAUSE;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        w_rd_mux = r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= c_IDLE;
      r_ovf     <= '0;
      r_rd_data <= '0;
      for (int i = 0; i <= NUM_EVT; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      // Shadows take the post-update, pre-clear values.
      if (snap_i) begin
        for (int i = 0; i <= NUM_EVT; i++) begin
          r_shadow[i] <= w_nxt[i];
        end
      end
      r_rd_data <= w_rd_mux;
      if (clear_i) begin
        r_state <= c_IDLE;
        r_ovf   <= '0;
        for (int i = 0; i <= NUM_EVT; i++) begin
          r_cnt[i] <= '0;
        end
      end else begin
        r_state <= w_state_nxt;
        r_ovf   <= r_ovf | w_ovf_set;
        for (int i = 0; i <= NUM_EVT; i++) begin
          r_cnt[i] <= w_nxt[i];
        end
      end
    end
  end

  assign rd_data_o = r_rd_data;
  assign cycle_o   = r_cnt[0];
  assign state_o   = r_state;
  assign done_o    = (r_state == c_DONE);
  assign ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_perf_monitor
// Brief    : Directed self-checking bench; a 32-bit monitor plus two 4-bit
//            monitors (saturating and wrapping) share one stimulus set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  evt = 4'd0;
  logic [31:0] limit = 32'd0;
  logic [3:0]  limit_s = 4'd0;
  logic        snap = 1'b0;
  logic [4:0]  rd_sel = 5'd0;

  logic [31:0] rd_data, cycle;
  logic [1:0]  state;
  logic        done;
  logic [4:0]  ovf;

  logic [3:0]  rd_s, cyc_s, rd_w, cyc_w;
  logic [1:0]  st_s, st_w;
  logic        done_s, done_w;
  logic [4:0]  ovf_s, ovf_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .SATURATE(1), .SEL_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_i(limit), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .cycle_o(cycle), .state_o(state), .done_o(done), .ovf_o(ovf));

  pipeline_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SATURATE(1), .SEL_W(5)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_i(limit_s), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_s),
    .cycle_o(cyc_s), .state_o(st_s), .done_o(done_s), .ovf_o(ovf_s));

  pipeline_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SATURATE(0), .SEL_W(5)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_i(limit_s), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_w),
    .cycle_o(cyc_w), .state_o(st_w), .done_o(done_w), .ovf_o(ovf_w));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Snapshot with counting stopped, then select sel; rd_* valid on return.
  task automatic snap_sel(input logic [4:0] sel);
    start = 1'b0;
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    rd_sel = sel;
    tick(1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL reset_cycle got=%0d want=0", cycle); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b want=00", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (ovf !== 5'd0) begin failures++; $display("FAIL reset_ovf got=%b want=00000", ovf); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd got=%0d want=0", rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_limit();
    limit = 32'd10;
    evt = 4'b0001;
    start = 1'b1;
    tick(9);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL lim_done_early got=%b want=0", done); end
    checks++; if (cycle !== 32'd9) begin failures++; $display("FAIL lim_cycle9 got=%0d want=9", cycle); end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL lim_state_run got=%b want=01", state); end
    tick(1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL lim_done got=%b want=1", done); end
    checks++; if (cycle !== 32'd10) begin failures++; $display("FAIL lim_cycle10 got=%0d want=10", cycle); end
    checks++; if (state !== 2'b11) begin failures++; $display("FAIL lim_state_done got=%b want=11", state); end
    evt = 4'b1111;
    tick(3);
    checks++; if (cycle !== 32'd10) begin failures++; $display("FAIL lim_frozen got=%0d want=10", cycle); end
    checks++; if (state !== 2'b11) begin failures++; $display("FAIL lim_stays_done got=%b want=11", state); end
    snap_sel(5'd1);
    checks++; if (rd_data !== 32'd10) begin failures++; $display("FAIL lim_evt0 got=%0d want=10", rd_data); end
    checks++; if (ovf !== 5'd0) begin failures++; $display("FAIL lim_ovf got=%b want=00000", ovf); end
  endtask

  task automatic test_pause();
    do_clear();
    limit = 32'd0;
    evt = 4'b0010;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    tick(4);
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL pause_state got=%b want=10", state); end
    checks++; if (cycle !== 32'd3) begin failures++; $display("FAIL pause_hold got=%0d want=3", cycle); end
    start = 1'b1;
    tick(2);
    checks++; if (cycle !== 32'd5) begin failures++; $display("FAIL pause_cycle got=%0d want=5", cycle); end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL pause_run got=%b want=01", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL pause_done got=%b want=0", done); end
    snap_sel(5'd2);
    checks++; if (rd_data !== 32'd5) begin failures++; $display("FAIL pause_evt1 got=%0d want=5", rd_data); end
  endtask

  task automatic test_saturation();
    do_clear();
    evt = 4'b0100;
    start = 1'b1;
    tick(20);
    checks++; if (cyc_s !== 4'd15) begin failures++; $display("FAIL sat_cycle got=%0d want=15", cyc_s); end
    checks++; if (ovf_s !== 5'b01001) begin failures++; $display("FAIL sat_ovf got=%b want=01001", ovf_s); end
    checks++; if (cyc_w !== 4'd4) begin failures++; $display("FAIL wrap_cycle got=%0d want=4", cyc_w); end
    checks++; if (ovf_w !== 5'b01001) begin failures++; $display("FAIL wrap_ovf got=%b want=01001", ovf_w); end
    snap_sel(5'd3);
    checks++; if (rd_s !== 4'd15) begin failures++; $display("FAIL sat_evt2 got=%0d want=15", rd_s); end
    checks++; if (rd_w !== 4'd4) begin failures++; $display("FAIL wrap_evt2 got=%0d want=4", rd_w); end
    checks++; if (ovf_s !== 5'b01001) begin failures++; $display("FAIL sat_ovf_sticky got=%b want=01001", ovf_s); end
  endtask

  task automatic test_snap_clear();
    do_clear();
    evt = 4'b0011;
    start = 1'b1;
    tick(7);
    start = 1'b0;
    snap = 1'b1;
    clear = 1'b1;
    tick(1);
    snap = 1'b0;
    clear = 1'b0;
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL sc_cycle got=%0d want=0", cycle); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL sc_state got=%b want=00", state); end
    rd_sel = 5'd0; tick(1);
    checks++; if (rd_data !== 32'd7) begin failures++; $display("FAIL sc_rd0 got=%0d want=7", rd_data); end
    rd_sel = 5'd1; tick(1);
    checks++; if (rd_data !== 32'd7) begin failures++; $display("FAIL sc_rd1 got=%0d want=7", rd_data); end
    rd_sel = 5'd2; tick(1);
    checks++; if (rd_data !== 32'd7) begin failures++; $display("FAIL sc_rd2 got=%0d want=7", rd_data); end
    rd_sel = 5'd3; tick(1);
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL sc_rd3 got=%0d want=0", rd_data); end
    rd_sel = 5'd6; tick(1);
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL sc_rd_oor got=%0d want=0", rd_data); end
  endtask

  task automatic test_reset_midrun();
    do_clear();
    evt = 4'b0001;
    start = 1'b1;
    tick(4);
    checks++; if (cycle !== 32'd4) begin failures++; $display("FAIL rm_cycle4 got=%0d want=4", cycle); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL rm_cycle0 got=%0d want=0", cycle); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL rm_state got=%b want=00", state); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL rm_rd got=%0d want=0", rd_data); end
    checks++; if (ovf_s !== 5'd0) begin failures++; $display("FAIL rm_ovf got=%b want=00000", ovf_s); end
    tick(1);
    checks++; if (cycle !== 32'd1) begin failures++; $display("FAIL rm_resume got=%0d want=1", cycle); end
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL rm_run got=%b want=01", state); end
  endtask

  task automatic test_clear_at_limit();
    do_clear();
    limit = 32'd3;
    evt = 4'b0000;
    start = 1'b1;
    tick(2);
    checks++; if (cycle !== 32'd2) begin failures++; $display("FAIL cl_cycle2 got=%0d want=2", cycle); end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    start = 1'b0;
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL cl_state got=%b want=00", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL cl_cycle got=%0d want=0", cycle); end
    tick(1);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL cl_done got=%b want=0", done); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL cl_idle got=%b want=00", state); end
  endtask

  initial begin
    test_reset();
    test_limit();
    test_pause();
    test_saturation();
    test_snap_clear();
    test_reset_midrun();
    test_clear_at_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_perf_monitor.md
Name: pipeline_perf_monitor

Overview:
Parametrised cycle and event counter for the pipelined CPU. Counts cycles and up to NUM_EVT event strobes, such as stall, flush, or stall-and-not-branch. Stops by itself at a programmable cycle limit. A snapshot/readout port lets a bench or debug host sample consistent counter values. Instantiated beside the CPU core and fed from the hazard, flush and control outputs.

Parameters:
NUM_EVT, 4, number of event channels (1..16)
CNT_W, 32, width of the cycle counter and of each event counter
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0
SEL_W, 5, width of rd_sel_i; must satisfy 2^SEL_W >= NUM_EVT+1

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  count enable; level-sensitive
clear_i  in  1  synchronous clear of counters, overflow flags and FSM
evt_i  in  NUM_EVT  event strobes; bit k = 1 counts one event on channel k this cycle
limit_i  in  CNT_W  cycle limit; 0 = unlimited
snap_i  in  1  copy live counters into the shadow bank
rd_sel_i  in  SEL_W  0 = cycle counter, k = event counter k-1
rd_data_o  out  CNT_W  registered shadow readout
cycle_o  out  CNT_W  live cycle count
state_o  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
done_o  out  1  high while in DONE
ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = event k-1

Behaviour:
- Reset (rst_i=1): all counters, shadows, rd_data_o, cycle_o and ovf_o = 0; state IDLE; done_o = 0. rst_i overrides every other input.
- Priority, highest first: rst_i > clear_i > limit/done logic > counting. snap_i is evaluated in parallel.
- clear_i: zeroes counters and ovf_o; state goes to IDLE. Shadows are untouched.
- FSM:
  - IDLE: start_i=1 -> RUN. Counting happens on this same edge, so the first start_i cycle is counted.
  - RUN: start_i=0 -> PAUSE, with no counting on that edge. Limit hit -> DONE.
  - PAUSE: counters hold; events are ignored. start_i=1 -> RUN and counts on that edge.
  - DONE: counters and ovf_o frozen. Exits only via clear_i or rst_i; start_i is ignored.
- Counting edge (state IDLE/RUN with start_i=1, or PAUSE with start_i=1): cycle counter += 1; event counter k += evt_i[k].
- Limit: if limit_i != 0 and the incremented cycle value equals limit_i, the new value is stored and state -> DONE on the same edge. done_o is high from the next cycle. Events on the final counting edge are counted.
- limit_i is sampled every cycle. If it is lowered below the current cycle count in RUN, the limit is never hit (equality compare); this is documented, not an error.
- Overflow:
  - SATURATE=1: a counter at all-ones stays at all-ones and sets its ovf bit.
  - SATURATE=0: the counter wraps to 0 and sets its ovf bit.
  - ovf bits are sticky until clear_i or rst_i.
- Snapshot: on an edge with snap_i=1, each shadow register gets the value its live counter holds after that edge's update. With clear_i in the same cycle, shadows get the pre-clear values.
- Readout: rd_data_o = shadow[rd_sel_i], registered, 1-cycle latency. An out-of-range rd_sel_i (> NUM_EVT) reads 0.
- cycle_o is the live counter, not the shadow.

Test Plan:
- Reset then start_i=1, evt_i=0001 every cycle, limit_i=10 -> done_o rises after 10th counting edge; cycle_o=10, event0=10, state_o=11; further start_i/evt_i change nothing.
- start_i high 3 cycles, low 4, high 2, limit_i=0, evt_i[1]=1 throughout -> cycle_o=5, event1=5, state_o=01, done_o=0.
- CNT_W=4, SATURATE=1, evt_i[2]=1 for 20 counting cycles -> event2=15, ovf_o[3]=1, cycle ovf_o[0]=1; repeat with SATURATE=0 -> event2=4, ovf bits set.
- After 7 counting cycles with evt_i=0011: assert snap_i and clear_i together, then rd_sel_i=0,1,2 -> rd_data_o = 7,7,7 one cycle after each select; cycle_o=0, state IDLE; rd_sel_i=6 -> 0.
- Mid-RUN at cycle_o=4, assert rst_i one cycle while start_i=1 -> next cycle all outputs 0, state IDLE; counting resumes with cycle_o=1 after rst_i drops.
- clear_i on same edge limit would be reached (limit_i=3, third counting edge) -> state IDLE, done_o stays 0, counters 0.
